// File: rtl/truth_table_scanner_if.sv
// Signal bundle between the truth-table scanner and its environment: the scan
// request, the function-under-test inputs/output and the captured results.
interface truth_table_scanner_if;
   logic        start;
   logic        nvars;
   logic [15:0] expected;
   logic        f_in;
   logic        x;
   logic        y;
   logic        z;
   logic        w;
   logic        busy;
   logic        done;
   logic [15:0] minterms;
   logic [4:0]  ones;
   logic        match;

   modport master (
      output start, nvars, expected, f_in,
      input  x, y, z, w, busy, done, minterms, ones, match
   );

   modport slave (
      input  start, nvars, expected, f_in,
      output x, y, z, w, busy, done, minterms, ones, match
   );
endinterface

// File: rtl/truth_table_scanner.sv
// Walks a 3- or 4-variable function through every input row, one row per
// cycle, captures its truth table, counts the ones and compares to a mask.
module truth_table_scanner (
   input  logic                   clk,
   input  logic                   rst_n,
   truth_table_scanner_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [3:0]  row_q, row_d;
   logic [15:0] minterms_q, minterms_d;
   logic [4:0]  ones_q, ones_d;
   logic        match_q, match_d;
   logic        nvars_q, nvars_d;

   logic [15:0] captured;
   logic [15:0] mask;
   logic [3:0]  last_idx;
   logic [3:0]  next_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= 4'd0;
         row_q      <= 4'd0;
         minterms_q <= 16'd0;
         ones_q     <= 5'd0;
         match_q    <= 1'b0;
         nvars_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         row_q      <= row_d;
         minterms_q <= minterms_d;
         ones_q     <= ones_d;
         match_q    <= match_d;
         nvars_q    <= nvars_d;
      end
   end

   // The row currently on x,y,z,w is idx_q; its f_in is captured on the next
   // edge, so the final compare must use the table including that last bit.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      row_d      = row_q;
      minterms_d = minterms_q;
      ones_d     = ones_q;
      match_d    = match_q;
      nvars_d    = nvars_q;

      captured = minterms_q | (16'(bus.f_in) << idx_q);
      mask     = nvars_q ? 16'hFFFF : 16'h00FF;
      last_idx = nvars_q ? 4'd15 : 4'd7;
      next_idx = idx_q + 4'd1;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d    = SCAN;
               idx_d      = 4'd0;
               row_d      = 4'd0;
               minterms_d = 16'd0;
               ones_d     = 5'd0;
               match_d    = 1'b0;
               nvars_d    = bus.nvars;
            end
         end
         SCAN: begin
            minterms_d = captured;
            ones_d     = ones_q + 5'(bus.f_in);
            if (idx_q == last_idx) begin
               state_d = DONE;
               row_d   = 4'd0;
               match_d = ((captured ^ bus.expected) & mask) == 16'd0;
            end else begin
               idx_d = next_idx;
               row_d = nvars_q ? next_idx : {next_idx[2:0], 1'b0};
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.x        = row_q[3];
   assign bus.y        = row_q[2];
   assign bus.z        = row_q[1];
   assign bus.w        = row_q[0];
   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = (state_q == DONE);
   assign bus.minterms = minterms_q;
   assign bus.ones     = ones_q;
   assign bus.match    = match_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner: expected results are queued
// when each scan is launched and popped when the DUT raises done.
module tb_truth_table_scanner;

   typedef struct packed {
      logic [15:0] mt;
      logic [4:0]  ones;
      logic        match;
   } res_t;

   logic clk;
   logic rst_n;
   int   fsel;
   int   total;
   int   bad;
   res_t sb[$];

   truth_table_scanner_if bus ();

   truth_table_scanner dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational function under test, selected per scenario.
   always_comb begin
      case (fsel)
         0:       bus.f_in = (~bus.y & bus.z) | (bus.x & bus.y);
         1:       bus.f_in = bus.w;
         2:       bus.f_in = 1'b1;
         default: bus.f_in = (bus.x & ~bus.w) | (bus.y ^ bus.z);
      endcase
   end

   function automatic logic fmodel(input int fs, input logic [3:0] r);
      logic xv, yv, zv, wv;
      {xv, yv, zv, wv} = r;
      case (fs)
         0:       return (~yv & zv) | (xv & yv);
         1:       return wv;
         2:       return 1'b1;
         default: return (xv & ~wv) | (yv ^ zv);
      endcase
   endfunction

   function automatic res_t model(input logic nv, input int fs, input logic [15:0] exp_mask);
      res_t        res;
      logic [3:0]  r;
      logic [15:0] m;
      int          n;
      n = nv ? 16 : 8;
      res = '0;
      for (int k = 0; k < n; k++) begin
         r = nv ? 4'(k) : {3'(k), 1'b0};
         res.mt[k] = fmodel(fs, r);
         res.ones  = res.ones + 5'(fmodel(fs, r));
      end
      m = nv ? 16'hFFFF : 16'h00FF;
      res.match = ((res.mt ^ exp_mask) & m) == 16'd0;
      return res;
   endfunction

   task automatic check_done_pop(output res_t want);
      total++;
      if (bus.done !== 1'b1) begin
         bad++;
         $display("[TB] FAIL done_pulse: got %b want 1", bus.done);
      end
      total++;
      if ({bus.x, bus.y, bus.z, bus.w} !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL row_in_done: got %b want 0000", {bus.x, bus.y, bus.z, bus.w});
      end
      want = '0;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("[TB] FAIL scoreboard_empty: got 0 entries want 1");
      end else begin
         want = sb.pop_front();
         total++;
         if (bus.minterms !== want.mt) begin
            bad++;
            $display("[TB] FAIL minterms: got %h want %h", bus.minterms, want.mt);
         end
         total++;
         if (bus.ones !== want.ones) begin
            bad++;
            $display("[TB] FAIL ones: got %0d want %0d", bus.ones, want.ones);
         end
         total++;
         if (bus.match !== want.match) begin
            bad++;
            $display("[TB] FAIL match: got %b want %b", bus.match, want.match);
         end
      end
   endtask

   // Launch one scan and follow it row by row; poke_row >= 0 pulses start mid-scan.
   task automatic run_scan(input logic nv, input int fs, input logic [15:0] exp_mask,
                           input int poke_row);
      int         n;
      logic [3:0] want_row;
      res_t       want;
      n = nv ? 16 : 8;
      @(negedge clk);
      fsel         = fs;
      bus.nvars    = nv;
      bus.expected = exp_mask;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 0; k < n; k++) begin
         want_row = nv ? 4'(k) : {3'(k), 1'b0};
         total++;
         if ({bus.x, bus.y, bus.z, bus.w} !== want_row) begin
            bad++;
            $display("[TB] FAIL row_seq[%0d]: got %b want %b", k, {bus.x, bus.y, bus.z, bus.w}, want_row);
         end
         total++;
         if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL busy_in_scan[%0d]: got busy=%b done=%b want busy=1 done=0", k, bus.busy, bus.done);
         end
         if (k == poke_row) begin
            bus.start = 1'b1;
            bus.nvars = ~nv;
         end else if (k == poke_row + 1) begin
            bus.start = 1'b0;
            bus.nvars = nv;
         end
         @(negedge clk);
      end
      check_done_pop(want);
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL after_done: got busy=%b done=%b want 0 0", bus.busy, bus.done);
      end
      total++;
      if (bus.minterms !== want.mt || bus.ones !== want.ones || bus.match !== want.match) begin
         bad++;
         $display("[TB] FAIL result_hold: got %h/%0d/%b want %h/%0d/%b",
                  bus.minterms, bus.ones, bus.match, want.mt, want.ones, want.match);
      end
   endtask

   task automatic check_all_zero(input string tag);
      total++;
      if ({bus.x, bus.y, bus.z, bus.w, bus.busy, bus.done, bus.match} !== 7'd0 ||
          bus.minterms !== 16'd0 || bus.ones !== 5'd0) begin
         bad++;
         $display("[TB] FAIL %s: got xyzw=%b busy=%b done=%b mt=%h ones=%0d match=%b want all 0",
                  tag, {bus.x, bus.y, bus.z, bus.w}, bus.busy, bus.done, bus.minterms, bus.ones, bus.match);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #3 check_all_zero("reset_state");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("idle_after_reset");
   endtask

   task automatic test_three_var();
      sb.push_back('{mt: 16'h00E2, ones: 5'd4, match: 1'b1});
      run_scan(1'b0, 0, 16'h00E2, -1);
   endtask

   task automatic test_masked_upper();
      sb.push_back('{mt: 16'h00E2, ones: 5'd4, match: 1'b1});
      run_scan(1'b0, 0, 16'hABE2, -1);
   endtask

   task automatic test_four_var_w();
      sb.push_back('{mt: 16'hAAAA, ones: 5'd8, match: 1'b0});
      run_scan(1'b1, 1, 16'hAAAB, -1);
   endtask

   task automatic test_all_ones();
      sb.push_back('{mt: 16'hFFFF, ones: 5'b10000, match: 1'b1});
      run_scan(1'b1, 2, 16'hFFFF, -1);
   endtask

   task automatic test_start_ignored();
      sb.push_back('{mt: 16'hAAAA, ones: 5'd8, match: 1'b1});
      run_scan(1'b1, 1, 16'hAAAA, 3);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      fsel         = 1;
      bus.nvars    = 1'b1;
      bus.expected = 16'hAAAA;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      total++;
      if ({bus.x, bus.y, bus.z, bus.w} !== 4'd5) begin
         bad++;
         $display("[TB] FAIL row_before_reset: got %b want 0101", {bus.x, bus.y, bus.z, bus.w});
      end
      rst_n = 1'b0;
      #1 check_all_zero("reset_mid_scan");
      @(negedge clk);
      rst_n = 1'b1;
      sb.push_back('{mt: 16'hAAAA, ones: 5'd8, match: 1'b1});
      run_scan(1'b1, 1, 16'hAAAA, -1);
   endtask

   task automatic test_random();
      logic        nv;
      logic [15:0] e;
      res_t        r;
      for (int i = 0; i < 4; i++) begin
         nv = i[0];
         r  = model(nv, 3, 16'h0000);
         e  = i[1] ? (r.mt | (nv ? 16'h0000 : (16'($urandom) & 16'hFF00))) : 16'($urandom);
         sb.push_back(model(nv, 3, e));
         run_scan(nv, 3, e, -1);
      end
   endtask

   task automatic test_back_to_back();
      int   dones;
      res_t want;
      dones = 0;
      @(negedge clk);
      fsel         = 3;
      bus.nvars    = 1'b0;
      bus.expected = 16'h0000;
      sb.push_back(model(1'b0, 3, 16'h0000));
      sb.push_back(model(1'b0, 3, 16'h0000));
      bus.start = 1'b1;
      for (int c = 0; c < 40 && dones < 2; c++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            check_done_pop(want);
            dones++;
            if (dones == 2) bus.start = 1'b0;
         end
      end
      total++;
      if (dones != 2) begin
         bad++;
         bus.start = 1'b0;
         $display("[TB] FAIL back_to_back_dones: got %0d want 2", dones);
      end
      repeat (3) @(negedge clk);
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL idle_after_release: got busy=%b want 0", bus.busy);
      end
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      fsel         = 0;
      bus.start    = 1'b0;
      bus.nvars    = 1'b0;
      bus.expected = 16'h0000;
      test_reset();
      test_three_var();
      test_masked_upper();
      test_four_var_w();
      test_all_ones();
      test_start_ignored();
      test_reset_mid();
      test_random();
      test_back_to_back();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("[TB] FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
